// File: rtl/memory_arbiter.sv
// ---------------------------------------------------------------------------
// memory_arbiter
//
// Purpose:
//   Shares one single-port RAM between the instruction-fetch (I) port and
//   the memory-stage data (D) port. It produces the one-cycle ihit/dhit
//   strobes that the hazard unit uses to stall or advance the pipeline.
//   Data requests take priority over instruction requests so that the
//   memory stage can drain. The arbiter aborts and re-arbitrates an access
//   when the RAM reports ERROR or does not return ACCESS within TIMEOUT
//   cycles. A saturating counter records each abort.
//
// Parameters:
//   TIMEOUT   cycles allowed in an access state before abort (>= 2)
//   ERRCNT_W  width of the saturating error/retry counter
//
// Ports:
//   i_clk        clock, all state on the rising edge
//   i_rst_n      asynchronous active-low reset
//   i_iren       instruction read request, held until o_ihit
//   i_iaddr      instruction word address
//   o_iload      registered instruction data, valid while o_ihit
//   o_ihit       one-cycle instruction-complete strobe
//   i_dren       data read request, held until o_dhit
//   i_dwen       data write request, held until o_dhit
//   i_daddr      data address
//   i_dstore     data write value
//   o_dload      registered read data, valid while o_dhit
//   o_dhit       one-cycle data-complete strobe
//   o_ramren     RAM read enable
//   o_ramwen     RAM write enable
//   o_ramaddr    RAM address
//   o_ramstore   RAM write data
//   i_ramload    RAM read data, valid when i_ramstate == ACCESS
//   i_ramstate   RAM status: 0 FREE, 1 BUSY, 2 ACCESS, 3 ERROR
//   o_errcnt     saturating count of ERROR/timeout aborts
// ---------------------------------------------------------------------------
module memory_arbiter #(
    parameter int TIMEOUT  = 64,
    parameter int ERRCNT_W = 8
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_iren,
    input  logic [31:0]         i_iaddr,
    output logic [31:0]         o_iload,
    output logic                o_ihit,
    input  logic                i_dren,
    input  logic                i_dwen,
    input  logic [31:0]         i_daddr,
    input  logic [31:0]         i_dstore,
    output logic [31:0]         o_dload,
    output logic                o_dhit,
    output logic                o_ramren,
    output logic                o_ramwen,
    output logic [31:0]         o_ramaddr,
    output logic [31:0]         o_ramstore,
    input  logic [31:0]         i_ramload,
    input  logic [1:0]          i_ramstate,
    output logic [ERRCNT_W-1:0] o_errcnt
);

    localparam logic [1:0] RAM_ACCESS = 2'd2;
    localparam logic [1:0] RAM_ERROR  = 2'd3;

    // The timer only has to reach TIMEOUT-1, so $clog2(TIMEOUT) bits suffice.
    localparam int TIMER_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DACC,
        S_IACC,
        S_DHIT,
        S_IHIT
    } state_t;

    state_t                r_state;
    logic                  r_ihit;
    logic                  r_dhit;
    logic [31:0]           r_iload;
    logic [31:0]           r_dload;
    logic [ERRCNT_W-1:0]   r_errcnt;
    logic [TIMER_W-1:0]    r_timer;

    logic                  w_d_req;
    logic                  w_ram_access;
    logic                  w_abort;
    logic                  w_errcnt_sat;

    assign w_d_req      = i_dren | i_dwen;
    assign w_ram_access = (i_ramstate == RAM_ACCESS);
    // ERROR and timeout both cause the same abort. ACCESS is checked first in the FSM.
    assign w_abort      = (i_ramstate == RAM_ERROR) || (r_timer == TIMER_LAST);
    assign w_errcnt_sat = &r_errcnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= S_IDLE;
            r_ihit   <= 1'b0;
            r_dhit   <= 1'b0;
            r_iload  <= '0;
            r_dload  <= '0;
            r_errcnt <= '0;
            r_timer  <= '0;
        end else begin
            // Hit strobes last exactly one cycle. They are only set on entry to a hit state.
            r_ihit <= 1'b0;
            r_dhit <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_timer <= '0;
                    if (w_d_req) begin
                        r_state <= S_DACC;
                    end else if (i_iren) begin
                        r_state <= S_IACC;
                    end
                end
                S_DACC: begin
                    // A withdrawn request is dropped without a hit, even if the
                    // RAM completes in the same cycle.
                    if (!w_d_req) begin
                        r_state <= S_IDLE;
                    end else if (w_ram_access) begin
                        r_dload <= i_ramload;
                        r_dhit  <= 1'b1;
                        r_state <= S_DHIT;
                    end else if (w_abort) begin
                        r_state <= S_IDLE;
                        if (!w_errcnt_sat) begin
                            r_errcnt <= r_errcnt + 1'b1;
                        end
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                S_IACC: begin
                    if (!i_iren) begin
                        r_state <= S_IDLE;
                    end else if (w_ram_access) begin
                        r_iload <= i_ramload;
                        r_ihit  <= 1'b1;
                        r_state <= S_IHIT;
                    end else if (w_abort) begin
                        r_state <= S_IDLE;
                        if (!w_errcnt_sat) begin
                            r_errcnt <= r_errcnt + 1'b1;
                        end
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                // The IDLE bubble after a hit gives the requester a cycle to
                // drop or change its request before it is re-arbitrated.
                S_DHIT:  r_state <= S_IDLE;
                S_IHIT:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // The RAM interface is decoded from state and the held request inputs
    // only. An asynchronous reset forces IDLE, so every enable drops at once.
    always_comb begin
        o_ramren   = 1'b0;
        o_ramwen   = 1'b0;
        o_ramaddr  = '0;
        o_ramstore = '0;
        case (r_state)
            S_DACC: begin
                o_ramaddr  = i_daddr;
                o_ramstore = i_dstore;
                o_ramwen   = i_dwen;
                o_ramren   = i_dren & ~i_dwen;
            end
            S_IACC: begin
                o_ramren  = 1'b1;
                o_ramaddr = i_iaddr;
            end
            default: begin
                o_ramren   = 1'b0;
                o_ramwen   = 1'b0;
                o_ramaddr  = '0;
                o_ramstore = '0;
            end
        endcase
    end

    assign o_ihit   = r_ihit;
    assign o_dhit   = r_dhit;
    assign o_iload  = r_iload;
    assign o_dload  = r_dload;
    assign o_errcnt = r_errcnt;

endmodule

// File: tb/tb_memory_arbiter.sv
// ---------------------------------------------------------------------------
// tb_memory_arbiter
//
// Purpose:
//   Self-checking bench for memory_arbiter. A cycle table drives the main
//   instance (default TIMEOUT) through an I read, a simultaneous I+D request,
//   an ERROR retry and an I withdrawal. Hand-written sequences cover wait
//   states and reset in the middle of an access. A second instance with
//   TIMEOUT=4 is held at BUSY to exercise timeout aborts and errcnt
//   saturation.
// ---------------------------------------------------------------------------
module tb_memory_arbiter;

    localparam logic [1:0] FREE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] ACC  = 2'd2;
    localparam logic [1:0] ERR  = 2'd3;

    logic        clk;
    logic        rst_n;

    // main instance
    logic        iren, dren, dwen;
    logic [31:0] iaddr, daddr, dstore, ramload;
    logic [1:0]  ramstate;
    logic [31:0] iload, dload, ramaddr, ramstore;
    logic        ihit, dhit, ramren, ramwen;
    logic [7:0]  errcnt;

    // timeout instance
    logic        t_iren, t_dren, t_dwen;
    logic [31:0] t_iaddr, t_daddr, t_dstore, t_ramload;
    logic [1:0]  t_ramstate;
    logic [31:0] t_iload, t_dload, t_ramaddr, t_ramstore;
    logic        t_ihit, t_dhit, t_ramren, t_ramwen;
    logic [7:0]  t_errcnt;

    int n_checks = 0;
    int n_errors = 0;

    memory_arbiter u_dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_iren     (iren),
        .i_iaddr    (iaddr),
        .o_iload    (iload),
        .o_ihit     (ihit),
        .i_dren     (dren),
        .i_dwen     (dwen),
        .i_daddr    (daddr),
        .i_dstore   (dstore),
        .o_dload    (dload),
        .o_dhit     (dhit),
        .o_ramren   (ramren),
        .o_ramwen   (ramwen),
        .o_ramaddr  (ramaddr),
        .o_ramstore (ramstore),
        .i_ramload  (ramload),
        .i_ramstate (ramstate),
        .o_errcnt   (errcnt)
    );

    memory_arbiter #(.TIMEOUT(4), .ERRCNT_W(8)) u_dut_to (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_iren     (t_iren),
        .i_iaddr    (t_iaddr),
        .o_iload    (t_iload),
        .o_ihit     (t_ihit),
        .i_dren     (t_dren),
        .i_dwen     (t_dwen),
        .i_daddr    (t_daddr),
        .i_dstore   (t_dstore),
        .o_dload    (t_dload),
        .o_dhit     (t_dhit),
        .o_ramren   (t_ramren),
        .o_ramwen   (t_ramwen),
        .o_ramaddr  (t_ramaddr),
        .o_ramstore (t_ramstore),
        .i_ramload  (t_ramload),
        .i_ramstate (t_ramstate),
        .o_errcnt   (t_errcnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        iren;
        logic [31:0] iaddr;
        logic        dren;
        logic        dwen;
        logic [31:0] daddr;
        logic [31:0] dstore;
        logic [31:0] ramload;
        logic [1:0]  ramstate;
        logic        e_ihit;
        logic        e_dhit;
        logic [31:0] e_iload;
        logic [31:0] e_dload;
        logic        e_ramren;
        logic        e_ramwen;
        logic [31:0] e_ramaddr;
        logic [31:0] e_ramstore;
        logic [7:0]  e_errcnt;
    } vec_t;

    localparam int NVEC = 21;
    vec_t vecs [NVEC];

    function automatic vec_t mk(
        input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
        input logic [31:0] da, input logic [31:0] ds, input logic [31:0] rl,
        input logic [1:0] rs,
        input logic eih, input logic edh, input logic [31:0] eil,
        input logic [31:0] edl, input logic err, input logic erw,
        input logic [31:0] era, input logic [31:0] ers, input logic [7:0] eec);
        vec_t v;
        v.iren = ir; v.iaddr = ia; v.dren = dr; v.dwen = dw;
        v.daddr = da; v.dstore = ds; v.ramload = rl; v.ramstate = rs;
        v.e_ihit = eih; v.e_dhit = edh; v.e_iload = eil; v.e_dload = edl;
        v.e_ramren = err; v.e_ramwen = erw; v.e_ramaddr = era;
        v.e_ramstore = ers; v.e_errcnt = eec;
        return v;
    endfunction

    task automatic check(input string name, input int idx,
                         input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s [%0d]: got %h, expected %h", name, idx, act, exp);
        end
    endtask

    task automatic idle_inputs();
        iren = 0; iaddr = 0; dren = 0; dwen = 0; daddr = 0; dstore = 0;
        ramload = 0; ramstate = FREE;
    endtask

    initial begin
        int acc_cnt;
        logic [7:0] exp_cnt;

        rst_n = 1'b0;
        idle_inputs();
        t_iren = 0; t_iaddr = 0; t_dren = 0; t_dwen = 0; t_daddr = 0;
        t_dstore = 0; t_ramload = 0; t_ramstate = BUSY;

        //                i  iaddr        d  w  daddr        dstore        ramload       rs  |ih dh iload         dload         rr rw ramaddr      ramstore      err
        // single I read: ihit two cycles after the request
        vecs[0]  = mk(1, 32'h40, 0, 0, 32'h0,   32'h0,        32'h0,        FREE, 0, 0, 32'h0,        32'h0,        0, 0, 32'h0,   32'h0,        8'd0);
        vecs[1]  = mk(1, 32'h40, 0, 0, 32'h0,   32'h0,        32'h8C220004, ACC,  0, 0, 32'h0,        32'h0,        1, 0, 32'h40,  32'h0,        8'd0);
        vecs[2]  = mk(1, 32'h40, 0, 0, 32'h0,   32'h0,        32'h0,        FREE, 1, 0, 32'h8C220004, 32'h0,        0, 0, 32'h0,   32'h0,        8'd0);
        vecs[3]  = mk(0, 32'h0,  0, 0, 32'h0,   32'h0,        32'h0,        FREE, 0, 0, 32'h8C220004, 32'h0,        0, 0, 32'h0,   32'h0,        8'd0);
        // simultaneous I + D write: D first, then I after the IDLE bubble
        vecs[4]  = mk(1, 32'h44, 0, 1, 32'h100, 32'hDEADBEEF, 32'h0,        FREE, 0, 0, 32'h8C220004, 32'h0,        0, 0, 32'h0,   32'h0,        8'd0);
        vecs[5]  = mk(1, 32'h44, 0, 1, 32'h100, 32'hDEADBEEF, 32'h0,        ACC,  0, 0, 32'h8C220004, 32'h0,        0, 1, 32'h100, 32'hDEADBEEF, 8'd0);
        vecs[6]  = mk(1, 32'h44, 0, 1, 32'h100, 32'hDEADBEEF, 32'h0,        FREE, 0, 1, 32'h8C220004, 32'h0,        0, 0, 32'h0,   32'h0,        8'd0);
        vecs[7]  = mk(1, 32'h44, 0, 0, 32'h0,   32'h0,        32'h0,        FREE, 0, 0, 32'h8C220004, 32'h0,        0, 0, 32'h0,   32'h0,        8'd0);
        vecs[8]  = mk(1, 32'h44, 0, 0, 32'h0,   32'h0,        32'h2402000A, ACC,  0, 0, 32'h8C220004, 32'h0,        1, 0, 32'h44,  32'h0,        8'd0);
        vecs[9]  = mk(1, 32'h44, 0, 0, 32'h0,   32'h0,        32'h0,        FREE, 1, 0, 32'h2402000A, 32'h0,        0, 0, 32'h0,   32'h0,        8'd0);
        vecs[10] = mk(0, 32'h0,  0, 0, 32'h0,   32'h0,        32'h0,        FREE, 0, 0, 32'h2402000A, 32'h0,        0, 0, 32'h0,   32'h0,        8'd0);
        // ERROR once, held read retries and completes
        vecs[11] = mk(0, 32'h0,  1, 0, 32'h200, 32'h55AA55AA, 32'h0,        FREE, 0, 0, 32'h2402000A, 32'h0,        0, 0, 32'h0,   32'h0,        8'd0);
        vecs[12] = mk(0, 32'h0,  1, 0, 32'h200, 32'h55AA55AA, 32'h0,        ERR,  0, 0, 32'h2402000A, 32'h0,        1, 0, 32'h200, 32'h55AA55AA, 8'd0);
        vecs[13] = mk(0, 32'h0,  1, 0, 32'h200, 32'h55AA55AA, 32'h0,        FREE, 0, 0, 32'h2402000A, 32'h0,        0, 0, 32'h0,   32'h0,        8'd1);
        vecs[14] = mk(0, 32'h0,  1, 0, 32'h200, 32'h55AA55AA, 32'hCAFEF00D, ACC,  0, 0, 32'h2402000A, 32'h0,        1, 0, 32'h200, 32'h55AA55AA, 8'd1);
        vecs[15] = mk(0, 32'h0,  1, 0, 32'h200, 32'h55AA55AA, 32'h0,        FREE, 0, 1, 32'h2402000A, 32'hCAFEF00D, 0, 0, 32'h0,   32'h0,        8'd1);
        vecs[16] = mk(0, 32'h0,  0, 0, 32'h0,   32'h0,        32'h0,        FREE, 0, 0, 32'h2402000A, 32'hCAFEF00D, 0, 0, 32'h0,   32'h0,        8'd1);
        // I request withdrawn while RAM is busy: no hit, no errcnt change
        vecs[17] = mk(1, 32'h48, 0, 0, 32'h0,   32'h0,        32'h0,        BUSY, 0, 0, 32'h2402000A, 32'hCAFEF00D, 0, 0, 32'h0,   32'h0,        8'd1);
        vecs[18] = mk(0, 32'h48, 0, 0, 32'h0,   32'h0,        32'h0,        BUSY, 0, 0, 32'h2402000A, 32'hCAFEF00D, 1, 0, 32'h48,  32'h0,        8'd1);
        vecs[19] = mk(0, 32'h0,  0, 0, 32'h0,   32'h0,        32'h0,        FREE, 0, 0, 32'h2402000A, 32'hCAFEF00D, 0, 0, 32'h0,   32'h0,        8'd1);
        vecs[20] = mk(0, 32'h0,  0, 0, 32'h0,   32'h0,        32'h0,        FREE, 0, 0, 32'h2402000A, 32'hCAFEF00D, 0, 0, 32'h0,   32'h0,        8'd1);

        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // ---------------- table-driven vectors ----------------
        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk);
            iren = vecs[i].iren; iaddr = vecs[i].iaddr;
            dren = vecs[i].dren; dwen = vecs[i].dwen;
            daddr = vecs[i].daddr; dstore = vecs[i].dstore;
            ramload = vecs[i].ramload; ramstate = vecs[i].ramstate;
            #1;
            check("ihit",     i, 32'(ihit),     32'(vecs[i].e_ihit));
            check("dhit",     i, 32'(dhit),     32'(vecs[i].e_dhit));
            check("iload",    i, iload,         vecs[i].e_iload);
            check("dload",    i, dload,         vecs[i].e_dload);
            check("ramren",   i, 32'(ramren),   32'(vecs[i].e_ramren));
            check("ramwen",   i, 32'(ramwen),   32'(vecs[i].e_ramwen));
            check("ramaddr",  i, ramaddr,       vecs[i].e_ramaddr);
            check("ramstore", i, ramstore,      vecs[i].e_ramstore);
            check("errcnt",   i, 32'(errcnt),   32'(vecs[i].e_errcnt));
            $display("vec %0d: ihit=%0b dhit=%0b ramren=%0b ramwen=%0b ramaddr=%h errcnt=%0d",
                     i, ihit, dhit, ramren, ramwen, ramaddr, errcnt);
        end

        // ---------------- wait states: 5 BUSY then ACCESS ----------------
        @(negedge clk);
        idle_inputs();
        dren = 1; daddr = 32'h300; dstore = 32'h12345678;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            ramstate = (c <= 5) ? BUSY : ACC;
            ramload  = (c <= 5) ? 32'h0 : 32'h0BADC0DE;
            #1;
            check("ws_ramren",   c, 32'(ramren), 32'd1);
            check("ws_ramaddr",  c, ramaddr,     32'h300);
            check("ws_ramstore", c, ramstore,    32'h12345678);
            check("ws_dhit",     c, 32'(dhit),   32'd0);
        end
        @(negedge clk);
        ramstate = FREE; ramload = 0;
        #1;
        check("ws_dhit_c7", 7, 32'(dhit),  32'd1);
        check("ws_dload",   7, dload,      32'h0BADC0DE);
        check("ws_ihit",    7, 32'(ihit),  32'd0);
        $display("wait-state read: dhit=%0b dload=%h", dhit, dload);
        @(negedge clk);
        dren = 0;
        #1;
        check("ws_dhit_c8", 8, 32'(dhit), 32'd0);

        // ---------------- reset in the middle of a D write ----------------
        @(negedge clk);
        dwen = 1; daddr = 32'h400; dstore = 32'hA5A5A5A5; ramstate = FREE;
        @(negedge clk);
        ramstate = BUSY;
        #1;
        check("rst_pre_ramwen", 0, 32'(ramwen), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_ramwen", 0, 32'(ramwen), 32'd0);
        check("rst_ramren", 0, 32'(ramren), 32'd0);
        check("rst_dhit",   0, 32'(dhit),   32'd0);
        check("rst_errcnt", 0, 32'(errcnt), 32'd0);
        check("rst_dload",  0, dload,       32'h0);
        $display("reset mid-DACC: ramwen=%0b dhit=%0b errcnt=%0d", ramwen, dhit, errcnt);
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b1;
        #1;
        check("post_rst_ramwen", 0, 32'(ramwen), 32'd0);

        // ---------------- timeout and saturation (TIMEOUT=4) ----------------
        // Each abort window is 4 ACC cycles followed by one IDLE cycle.
        t_dren = 1; t_daddr = 32'h500; t_ramstate = BUSY;
        for (int n = 1; n <= 260; n++) begin
            acc_cnt = 0;
            for (int k = 0; k < 5; k++) begin
                @(posedge clk);
                #1;
                if (t_ramren) acc_cnt++;
                if (k == 3) begin
                    exp_cnt = (n - 1 > 255) ? 8'd255 : 8'(n - 1);
                    check("to_errcnt_pre", n, 32'(t_errcnt), 32'(exp_cnt));
                end
            end
            exp_cnt = (n > 255) ? 8'd255 : 8'(n);
            check("to_acc_cycles", n, acc_cnt,        32'd4);
            check("to_errcnt",     n, 32'(t_errcnt),  32'(exp_cnt));
            check("to_no_dhit",    n, 32'(t_dhit),    32'd0);
            if (n <= 3 || n >= 254)
                $display("abort %0d: acc_cycles=%0d errcnt=%0d", n, acc_cnt, t_errcnt);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
